// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron command sequencer: opcodes, FSM encodings,
// reset threshold and the saturating spike counter step.
package neuron_pkg;

    localparam logic [2:0] OP_LOAD_W = 3'd0;
    localparam logic [2:0] OP_LOAD_X = 3'd1;
    localparam logic [2:0] OP_SET_TH = 3'd2;
    localparam logic [2:0] OP_SET_SH = 3'd3;
    localparam logic [2:0] OP_RUN    = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;

    localparam int THETA_RST = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
    } cmd_t;

    // Spike counter sticks at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] count, input logic inc);
        return (inc && (count != 8'hFF)) ? count + 8'd1 : count;
    endfunction

endpackage

// File: rtl/neuron_cmd_sequencer.sv
// Command-driven controller for the LIF neuron datapath: byte-serial weight/input
// loading, threshold/leak configuration and gated membrane updates for N timesteps.
module neuron_cmd_sequencer
    import neuron_pkg::*;
#(
    parameter int N_STAGES = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [7:0]              cmd_data,
    output logic [2**N_STAGES-1:0]  w_o,
    output logic [2**N_STAGES-1:0]  x_o,
    output logic [2:0]              shift_o,
    output logic [N_STAGES+1:0]     minus_teta_o,
    output logic [N_STAGES+1:0]     prev_u_o,
    output logic                    was_spike_o,
    input  logic [N_STAGES+1:0]     u_in,
    input  logic                    spike_in,
    output logic                    busy,
    output logic                    step_done,
    output logic [7:0]              spike_count
);

    localparam int INPUTS = 2**N_STAGES;
    localparam int PREC   = N_STAGES + 2;
    localparam logic [PREC-1:0] MINUS_THETA_RST = PREC'(-THETA_RST);

    logic [0:0]        state_reg;
    logic [7:0]        steps_reg;
    logic [INPUTS-1:0] w_reg;
    logic [INPUTS-1:0] x_reg;
    logic [2:0]        shift_reg;
    logic [PREC-1:0]   minus_teta_reg;
    logic [PREC-1:0]   prev_u_reg;
    logic              was_spike_reg;
    logic [7:0]        spike_count_reg;
    logic              step_done_reg;

    cmd_t            cmd;
    logic            cmd_accept;
    logic [PREC-1:0] th_mag;

    assign cmd        = '{op: cmd_op, data: cmd_data};
    assign cmd_ready  = (state_reg == ST_IDLE) && !reset;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign th_mag     = PREC'(cmd.data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            steps_reg       <= 8'd0;
            w_reg           <= '0;
            x_reg           <= '0;
            shift_reg       <= 3'd0;
            minus_teta_reg  <= MINUS_THETA_RST;
            prev_u_reg      <= '0;
            was_spike_reg   <= 1'b0;
            spike_count_reg <= 8'd0;
            step_done_reg   <= 1'b0;
        end else begin
            step_done_reg <= 1'b0;
            if (state_reg == ST_RUN) begin
                // One neuron timestep per cycle; the last step hands back to IDLE.
                prev_u_reg      <= u_in;
                was_spike_reg   <= spike_in;
                spike_count_reg <= sat_inc(spike_count_reg, spike_in);
                steps_reg       <= steps_reg - 8'd1;
                if (steps_reg == 8'd1) begin
                    state_reg     <= ST_IDLE;
                    step_done_reg <= 1'b1;
                end
            end else if (cmd_accept) begin
                case (cmd.op)
                    OP_LOAD_W: w_reg          <= {w_reg[INPUTS-9:0], cmd.data};
                    OP_LOAD_X: x_reg          <= {x_reg[INPUTS-9:0], cmd.data};
                    OP_SET_TH: minus_teta_reg <= {PREC{1'b0}} - th_mag;
                    OP_SET_SH: shift_reg      <= cmd.data[2:0];
                    OP_RUN: begin
                        steps_reg <= cmd.data;
                        if (cmd.data == 8'd0) begin
                            step_done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                    OP_CLEAR: begin
                        prev_u_reg      <= '0;
                        was_spike_reg   <= 1'b0;
                        spike_count_reg <= 8'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_o          = w_reg;
    assign x_o          = x_reg;
    assign shift_o      = shift_reg;
    assign minus_teta_o = minus_teta_reg;
    assign prev_u_o     = prev_u_reg;
    assign was_spike_o  = was_spike_reg;
    assign busy         = (state_reg == ST_RUN);
    assign step_done    = step_done_reg;
    assign spike_count  = spike_count_reg;

endmodule

// File: tb/tb_neuron_cmd_sequencer.sv
// Self-checking bench for neuron_cmd_sequencer: command tables, multi-cycle corner
// sequences and a randomized command stream against a command-level reference model.
module tb_neuron_cmd_sequencer;
    import neuron_pkg::*;

    localparam int N_STAGES = 6;
    localparam int INPUTS   = 64;
    localparam int PREC     = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [7:0]        cmd_data = 8'd0;
    logic [INPUTS-1:0] w_o, x_o;
    logic [2:0]        shift_o;
    logic [PREC-1:0]   minus_teta_o, prev_u_o, u_in;
    logic              was_spike_o, spike_in, busy, step_done;
    logic [7:0]        spike_count;

    logic            use_model = 1'b0;
    logic [PREC-1:0] stub_u = '0;
    logic            stub_spike = 1'b0;
    logic [PREC-1:0] model_u;
    logic            model_spike;

    int tests = 0;
    int fails = 0;

    // Command-level reference state
    logic [63:0] mw, mx;
    logic [7:0]  mth, mu;
    logic [2:0]  msh;
    logic        mws;
    int          mcnt;

    neuron_cmd_sequencer #(.N_STAGES(N_STAGES)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .w_o(w_o), .x_o(x_o), .shift_o(shift_o),
        .minus_teta_o(minus_teta_o), .prev_u_o(prev_u_o), .was_spike_o(was_spike_o),
        .u_in(u_in), .spike_in(spike_in), .busy(busy), .step_done(step_done),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    // Stand-in combinational LIF neuron: leak by arithmetic shift, reset after a
    // spike, integrate popcount(w & x), spike when u reaches the threshold.
    function automatic logic [8:0] neuron_ref(input logic [63:0] w, input logic [63:0] x,
                                              input logic [2:0] sh, input logic [7:0] mteta,
                                              input logic [7:0] prev, input logic ws);
        int pu, acc;
        logic [7:0] u;
        logic spk;
        pu  = $signed(prev);
        acc = ws ? 0 : pu - (pu >>> sh);
        acc = acc + $countones(w & x);
        u   = acc[7:0];
        spk = (int'($signed(u)) + int'($signed(mteta))) >= 0;
        return {spk, u};
    endfunction

    always_comb begin
        {model_spike, model_u} = neuron_ref(w_o, x_o, shift_o, minus_teta_o, prev_u_o, was_spike_o);
    end
    assign u_in     = use_model ? model_u : stub_u;
    assign spike_in = use_model ? model_spike : stub_spike;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer a command and hold it until accepted; waits = cycles spent stalled.
    task automatic issue(input logic [2:0] op, input logic [7:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!cmd_ready && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 2000) begin
            tests++; fails++;
            $display("FAIL issue_timeout: got no cmd_ready expected cmd_ready within 2000 cycles");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Called right after a RUN was accepted; observes the following n+3 cycles.
    task automatic run_measure(input int n, output int busy_n, output int done_n, output int nready_n);
        busy_n = 0; done_n = 0; nready_n = 0;
        for (int i = 0; i < n + 3; i++) begin
            busy_n   += int'(busy);
            done_n   += int'(step_done);
            nready_n += int'(!cmd_ready);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mw = '0; mx = '0; mth = 8'hFB; msh = 3'd0; mu = 8'd0; mws = 1'b0; mcnt = 0;
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_w"},     w_o, mw);
        check({tag, "_x"},     x_o, mx);
        check({tag, "_th"},    minus_teta_o, mth);
        check({tag, "_sh"},    shift_o, msh);
        check({tag, "_u"},     prev_u_o, mu);
        check({tag, "_ws"},    was_spike_o, mws);
        check({tag, "_cnt"},   spike_count, mcnt);
        check({tag, "_busy"},  busy, 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  data;
        int          sel;     // 0 w_o, 1 x_o, 2 minus_teta_o, 3 shift_o
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[21];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1);
    end

    initial begin
        int w, b, d, nr;
        logic [63:0] acc;
        logic [8:0]  ref_out;
        logic [2:0]  op;
        logic [7:0]  dat;

        // Table: T1 byte-serial loads (first byte ends up MSB), T2 threshold/shift.
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = (acc << 8) | 64'(k + 1);
            vecs[k].op = OP_LOAD_W; vecs[k].data = 8'(k + 1); vecs[k].sel = 0; vecs[k].exp = acc;
        end
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = (acc << 8) | 64'(8'hF0 + k);
            vecs[8+k].op = OP_LOAD_X; vecs[8+k].data = 8'(8'hF0 + k); vecs[8+k].sel = 1; vecs[8+k].exp = acc;
        end
        vecs[16] = '{op: OP_SET_TH, data: 8'd3,   sel: 2, exp: 64'hFD};
        vecs[17] = '{op: OP_SET_TH, data: 8'd0,   sel: 2, exp: 64'h00};
        vecs[18] = '{op: OP_SET_TH, data: 8'd255, sel: 2, exp: 64'h01};
        vecs[19] = '{op: OP_SET_SH, data: 8'd9,   sel: 3, exp: 64'h1};
        vecs[20] = '{op: OP_SET_SH, data: 8'd7,   sel: 3, exp: 64'h7};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_w", w_o, 0);
        check("rst_x", x_o, 0);
        check("rst_sh", shift_o, 0);
        check("rst_th", minus_teta_o, 8'hFB);
        check("rst_u", prev_u_o, 0);
        check("rst_ws", was_spike_o, 0);
        check("rst_cnt", spike_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", step_done, 0);
        check("rst_ready", cmd_ready, 1);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].data, w);
            check($sformatf("vec%0d_ready", i), w, 0);
            case (vecs[i].sel)
                0:       check($sformatf("vec%0d_w", i), w_o, vecs[i].exp);
                1:       check($sformatf("vec%0d_x", i), x_o, vecs[i].exp);
                2:       check($sformatf("vec%0d_th", i), minus_teta_o, vecs[i].exp);
                default: check($sformatf("vec%0d_sh", i), shift_o, vecs[i].exp);
            endcase
        end

        // T3: RUN 4 with a constant stub neuron output
        stub_u = 8'h2A; stub_spike = 1'b1;
        issue(OP_RUN, 8'd4, w);
        run_measure(4, b, d, nr);
        check("t3_busy_cycles", b, 4);
        check("t3_ready_low", nr, 4);
        check("t3_done_pulses", d, 1);
        check("t3_u", prev_u_o, 8'h2A);
        check("t3_ws", was_spike_o, 1);
        check("t3_cnt", spike_count, 4);

        // Command offered mid-RUN stalls until the RUN completes
        issue(OP_RUN, 8'd5, w);
        issue(OP_SET_SH, 8'd6, w);
        check("hold_waits", w, 5);
        check("hold_sh", shift_o, 6);
        check("hold_cnt", spike_count, 9);

        // T4: CLEAR, saturation, RUN 0
        issue(OP_CLEAR, 8'd0, w);
        check("clr_u", prev_u_o, 0);
        check("clr_ws", was_spike_o, 0);
        check("clr_cnt", spike_count, 0);
        issue(OP_RUN, 8'd255, w);
        run_measure(255, b, d, nr);
        check("t4_busy255", b, 255);
        check("t4_cnt255", spike_count, 255);
        issue(OP_RUN, 8'd3, w);
        run_measure(3, b, d, nr);
        check("t4_cnt_sat", spike_count, 255);
        stub_u = 8'h11; stub_spike = 1'b0;
        @(negedge clk);
        #1 check("t4_run0_done_before", step_done, 0);
        issue(OP_RUN, 8'd0, w);
        run_measure(0, b, d, nr);
        check("t4_run0_busy", b, 0);
        check("t4_run0_done", d, 1);
        check("t4_run0_u", prev_u_o, 8'h2A);
        check("t4_run0_ws", was_spike_o, 1);
        check("t4_run0_cnt", spike_count, 255);

        // T5: reset during the 3rd busy cycle of RUN 10
        stub_u = 8'h33; stub_spike = 1'b1;
        issue(OP_RUN, 8'd10, w);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD_W; cmd_data = 8'hAA;
        #1 check("t5_ready_in_reset", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", step_done, 0);
        check("t5_u", prev_u_o, 0);
        check("t5_cnt", spike_count, 0);
        check("t5_th", minus_teta_o, 8'hFB);
        check("t5_sh", shift_o, 0);
        @(posedge clk);
        #1 check("t5_no_accept_w", w_o, 0);
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0;
        run_measure(12, b, d, nr);
        check("t5_after_busy", b, 0);
        check("t5_after_done", d, 0);

        // T6: stand-in neuron, all-ones weights/inputs, threshold 5, one step
        do_reset();
        use_model = 1'b1;
        for (int k = 0; k < 8; k++) issue(OP_LOAD_W, 8'hFF, w);
        for (int k = 0; k < 8; k++) issue(OP_LOAD_X, 8'hFF, w);
        issue(OP_SET_TH, 8'd5, w);
        ref_out = neuron_ref({64{1'b1}}, {64{1'b1}}, 3'd0, 8'hFB, 8'd0, 1'b0);
        issue(OP_RUN, 8'd1, w);
        run_measure(1, b, d, nr);
        check("t6_busy", b, 1);
        check("t6_u", prev_u_o, ref_out[7:0]);
        check("t6_u_const", prev_u_o, 8'd64);
        check("t6_ws", was_spike_o, 1);
        check("t6_cnt", spike_count, 1);
        use_model = 1'b0;

        // Randomized command stream against the command-level model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 7));
            dat = 8'($urandom_range(0, 255));
            if (op == OP_RUN) begin
                dat = 8'($urandom_range(0, 20));
                stub_u = 8'($urandom_range(0, 255));
                stub_spike = 1'($urandom_range(0, 1));
                issue(op, dat, w);
                run_measure(int'(dat), b, d, nr);
                check($sformatf("rnd%0d_busy", i), b, dat);
                check($sformatf("rnd%0d_done", i), d, 1);
                if (dat != 0) begin
                    mu = stub_u; mws = stub_spike;
                    mcnt = mcnt + int'(dat) * int'(stub_spike);
                    if (mcnt > 255) mcnt = 255;
                end
            end else begin
                issue(op, dat, w);
                case (op)
                    OP_LOAD_W: mw = (mw << 8) | 64'(dat);
                    OP_LOAD_X: mx = (mx << 8) | 64'(dat);
                    OP_SET_TH: mth = 8'((256 - int'(dat)) % 256);
                    OP_SET_SH: msh = dat % 8;
                    OP_CLEAR: begin mu = 0; mws = 0; mcnt = 0; end
                    default: ;
                endcase
            end
            compare_state($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
